calculadora_tester: RTL and testbench

- Self-checking initiator for the 8-bit calculator: generates pseudo-random operand/mode streams, drives the calculator's a/b/MODO/enb inputs, and consumes its registered result c.
- Compares each result against an internal golden model and keeps pass/fail statistics.
- Sits beside the calculator in the board-level self-test wrapper and is triggered by a start pulse.

---
 rtl/calculadora_tester.sv | 180 ++++++++++++++++++
 tb/tb_calculadora_tester.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/calculadora_tester.sv
// Self-test initiator for the 8-bit calculator: issues LFSR-driven operand/mode
// streams, checks each registered result against a golden model, keeps statistics.
module calculadora_tester #(
  parameter logic [15:0] LFSR_POLY = 16'hB400,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] num_ops,
  output logic [7:0]       calc_a,
  output logic [7:0]       calc_b,
  output logic [1:0]       calc_modo,
  output logic             calc_enb,
  input  logic [7:0]       calc_c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             mismatch
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ZCHK  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]       state_r;
  logic [15:0]      lfsr_r;
  logic [CNT_W-1:0] op_idx_r;
  logic [CNT_W-1:0] n_ops_r;
  logic [7:0]       exp_val_r;
  logic             exp_vld_r;
  logic [CNT_W-1:0] exp_idx_r;

  logic [15:0]      seed_eff_s;
  logic [CNT_W-1:0] last_idx_s;
  logic [CNT_W-1:0] next_idx_s;
  logic             accept_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] sh;
    sh = {1'b0, l[15:1]};
    return l[0] ? (sh ^ LFSR_POLY) : sh;
  endfunction

  function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] modo);
    logic [7:0] r;
    case (modo)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a * b;
      2'b11:   r = (b >= 8'd8) ? 8'd0 : (a << b[2:0]);
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  assign seed_eff_s = (seed == 16'd0) ? 16'd1 : seed;
  assign last_idx_s = n_ops_r - CNT_ONE;
  assign next_idx_s = op_idx_r + CNT_ONE;
  assign accept_s   = (state_r == S_IDLE) && start;

  // Run sequencing and registered operand issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      lfsr_r    <= 16'd0;
      op_idx_r  <= CNT_ZERO;
      n_ops_r   <= CNT_ZERO;
      calc_a    <= 8'd0;
      calc_b    <= 8'd0;
      calc_modo <= 2'd0;
      calc_enb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            n_ops_r  <= num_ops;
            op_idx_r <= CNT_ZERO;
            busy     <= 1'b1;
            done     <= 1'b0;
            if (num_ops == CNT_ZERO) begin
              state_r  <= S_DRAIN;
              lfsr_r   <= seed_eff_s;
              calc_enb <= 1'b0;
            end else begin
              // op 0 is presented straight from the seed during the first ISSUE cycle
              state_r   <= S_ISSUE;
              calc_a    <= seed_eff_s[7:0];
              calc_b    <= seed_eff_s[15:8];
              calc_modo <= 2'd0;
              calc_enb  <= 1'b1;
              lfsr_r    <= lfsr_step(seed_eff_s);
            end
          end
        end
        S_ISSUE: begin
          if (op_idx_r == last_idx_s) begin
            state_r  <= S_DRAIN;
            calc_enb <= 1'b0;
          end else begin
            op_idx_r  <= next_idx_s;
            calc_a    <= lfsr_r[7:0];
            calc_b    <= lfsr_r[15:8];
            calc_modo <= next_idx_s[1:0];
            calc_enb  <= 1'b1;
            lfsr_r    <= lfsr_step(lfsr_r);
          end
        end
        S_DRAIN: begin
          state_r <= S_ZCHK;
        end
        S_ZCHK: begin
          state_r <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          calc_enb <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Expected-result pipeline, aligned with the calculator's one-cycle latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_val_r <= 8'd0;
      exp_vld_r <= 1'b0;
      exp_idx_r <= CNT_ZERO;
    end else begin
      exp_vld_r <= (state_r == S_ISSUE) || (state_r == S_DRAIN);
      exp_val_r <= (state_r == S_ISSUE) ? golden(calc_a, calc_b, calc_modo) : 8'd0;
      exp_idx_r <= (state_r == S_ISSUE) ? op_idx_r : n_ops_r;
    end
  end

  // Compare and saturating statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt       <= CNT_ZERO;
      fail_cnt       <= CNT_ZERO;
      first_fail_idx <= CNT_MAX;
      mismatch       <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (accept_s) begin
        pass_cnt       <= CNT_ZERO;
        fail_cnt       <= CNT_ZERO;
        first_fail_idx <= CNT_MAX;
      end else if (exp_vld_r) begin
        if (calc_c == exp_val_r) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
        end else begin
          mismatch <= 1'b1;
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
          // fail_cnt saturates but never returns to zero, so it marks the first failure
          if (fail_cnt == CNT_ZERO) first_fail_idx <= exp_idx_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_calculadora_tester.sv
// Bench for calculadora_tester: behavioural calculator with injectable faults,
// a table of runs checked against an arithmetic reference model.
module tb_calculadora_tester;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = 16'd0;
  logic [7:0]  num_ops = 8'd0;
  logic [7:0]  calc_a, calc_b, calc_c, calc_q;
  logic [1:0]  calc_modo;
  logic        calc_enb, busy, done, mismatch;
  logic [7:0]  pass_cnt, fail_cnt, first_fail_idx;
  int          fault = 0;
  int          n_total = 0;
  int          n_pass = 0;

  typedef struct {
    int seed; int n; int fault; int poke;
    int exp_pass; int exp_fail; int exp_first;
  } vec_t;
  vec_t tbl[10];

  int exp_a[256], exp_b[256], exp_m[256];
  bit fail_at[258];
  bit busy_log[260], enb_log[260], done_log[260], mm_log[260];
  int a_log[260], b_log[260], m_log[260];

  always #5 clk = ~clk;

  calculadora_tester #(.LFSR_POLY(16'hB400), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_ops(num_ops),
    .calc_a(calc_a), .calc_b(calc_b), .calc_modo(calc_modo), .calc_enb(calc_enb),
    .calc_c(calc_c), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx), .mismatch(mismatch)
  );

  function automatic logic [7:0] ref_result(input int a, input int b, input int m);
    int v;
    case (m)
      0:       v = (a + b) % 256;
      1:       v = (a - b + 256) % 256;
      2:       v = (a * b) % 256;
      default: v = (b >= 8) ? 0 : (a * (1 << b)) % 256;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [7:0] apply_fault(input logic [7:0] v, input int f);
    if (f == 1) return v | 8'h01;
    else if (f == 2) return 8'h55;
    else return v;
  endfunction

  // calculator: registered result, zero while not enabled
  always @(posedge clk)
    calc_q <= calc_enb ? ref_result(int'(calc_a), int'(calc_b), int'(calc_modo)) : 8'd0;
  assign calc_c = apply_fault(calc_q, fault);

  function automatic int lfsr_next(input int l);
    if (l % 2 == 1) return (l / 2) ^ 32'hB400;
    else return l / 2;
  endfunction

  function automatic int lfsr_prev(input int n);
    if (n >= 32768) return ((n ^ 32'hB400) * 2) + 1;
    else return n * 2;
  endfunction

  task automatic model_run(input int s, input int n, input int f,
                           output int p, output int fl, output int first);
    int l, good, np, nf;
    l = (s == 0) ? 1 : s;
    np = 0; nf = 0; first = 255;
    for (int k = 0; k < n; k++) begin
      exp_a[k] = l % 256; exp_b[k] = l / 256; exp_m[k] = k % 4;
      good = int'(ref_result(exp_a[k], exp_b[k], exp_m[k]));
      fail_at[k] = (int'(apply_fault(good[7:0], f)) != good);
      l = lfsr_next(l);
    end
    fail_at[n] = (apply_fault(8'd0, f) != 8'd0);
    fail_at[n+1] = 1'b0;
    for (int k = 0; k <= n; k++) begin
      if (fail_at[k]) begin
        nf++;
        if (first == 255 && nf == 1) first = k;
      end else np++;
    end
    p = (np > 255) ? 255 : np;
    fl = (nf > 255) ? 255 : nf;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic run_one(input vec_t v);
    int p, fl, fi, bad_shape, bad_ops;
    bit mm_exp;
    model_run(v.seed, v.n, v.fault, p, fl, fi);
    fault = v.fault;
    @(posedge clk); #1;
    seed = 16'(v.seed); num_ops = 8'(v.n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j <= v.n + 3; j++) begin
      busy_log[j] = busy; enb_log[j] = calc_enb; done_log[j] = done; mm_log[j] = mismatch;
      a_log[j] = int'(calc_a); b_log[j] = int'(calc_b); m_log[j] = int'(calc_modo);
      if (j == v.poke) begin
        seed = 16'h1234; num_ops = 8'd5; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bad_shape = 0; bad_ops = 0;
    for (int j = 0; j <= v.n + 3; j++) begin
      mm_exp = (j >= 2) ? fail_at[j-2] : 1'b0;
      if (busy_log[j] != (j < v.n + 2)) bad_shape++;
      if (enb_log[j] != (j < v.n)) bad_shape++;
      if (done_log[j] != (j >= v.n + 2)) bad_shape++;
      if (mm_log[j] != mm_exp) bad_shape++;
    end
    for (int k = 0; k < v.n; k++)
      if (a_log[k] != exp_a[k] || b_log[k] != exp_b[k] || m_log[k] != exp_m[k]) bad_ops++;
    check("timing_shape", bad_shape, 0);
    check("operands", bad_ops, 0);
    check("pass_cnt", int'(pass_cnt), v.exp_pass);
    check("fail_cnt", int'(fail_cnt), v.exp_fail);
    check("first_fail_idx", int'(first_fail_idx), v.exp_first);
  endtask

  initial begin
    int p, fl, fi, sh, s, n, f, pk;
    #23;
    check("rst_enb", int'(calc_enb), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass_cnt), 0);
    check("rst_fail", int'(fail_cnt), 0);
    check("rst_first", int'(first_fail_idx), 255);
    check("rst_mismatch", int'(mismatch), 0);
    check("rst_a", int'(calc_a), 0);
    rst = 1'b1;

    sh = 32'h0AFF;
    for (int i = 0; i < 3; i++) sh = lfsr_prev(sh);

    tbl[0] = '{1, 16, 0, 3, 17, 0, 255};
    tbl[1] = '{1, 0, 0, 2, 1, 0, 255};
    tbl[2] = '{sh, 8, 0, -1, 9, 0, 255};
    model_run(32'h0202, 4, 1, p, fl, fi);
    tbl[3] = '{32'h0202, 4, 1, 5, p, fl, fi};
    model_run(32'h5A5A, 255, 2, p, fl, fi);
    tbl[4] = '{32'h5A5A, 255, 2, 100, p, fl, fi};
    for (int i = 5; i < 10; i++) begin
      s = int'($urandom_range(65535, 0));
      n = int'($urandom_range(40, 1));
      f = int'($urandom_range(2, 0));
      pk = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n + 2, 0)) : -1;
      model_run(s, n, f, p, fl, fi);
      tbl[i] = '{s, n, f, pk, p, fl, fi};
    end

    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i]);
      if (i == 2) begin
        check("shift_op3_a", a_log[3], 255);
        check("shift_op3_b", b_log[3], 10);
        check("shift_op3_modo", m_log[3], 3);
      end
      if (i == 3) check("bit0_first_idx", int'(first_fail_idx), 0);
      if (i == 4) check("sat_fail_cnt", int'(fail_cnt), 255);
      if (i == 1) check("zero_ops_done_at_3", int'(done_log[1]) * 2 + int'(done_log[2]), 1);
    end

    // abort a run mid-ISSUE with an asynchronous reset
    fault = 0;
    @(posedge clk); #1;
    seed = 16'h0001; num_ops = 8'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_enb", int'(calc_enb), 1);
    rst = 1'b0;
    #1;
    check("async_enb_drop", int'(calc_enb), 0);
    check("async_busy_drop", int'(busy), 0);
    check("async_first_idx", int'(first_fail_idx), 255);
    #2;
    rst = 1'b1;
    run_one('{0, 16, 0, -1, 17, 0, 255});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
